hc165_scan_ctrl: RTL and testbench
==================================

# hc165_scan_ctrl

Sequencer for a daisy-chain of 74HC165 parallel-in/serial-out shift registers on the input board. On request it pulses the parallel load, waits out recovery, toggles the shift clock with clock-enable asserted, and deserialises the chain output into a parallel word with a one-cycle valid strobe. It sits between the input pins and the controller-state logic and replaces hand-sequenced PL_n/CP/CE_n control.

## Interface

- NUM_BITS, 16, total chain length in bits (8 per chip); must be ≥1
- CP_HALF, 4, sr_cp half-period in clk cycles; must be ≥3
- PL_CYCLES, 2, sr_pl_n low width in clk cycles; must be ≥1
- REC_CYCLES, 3, cycles from sr_pl_n release to the first sr_cp rise window; must be ≥1

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  scan request, sampled only in IDLE
- sr_q7  input  1  serial data from the last chip's Q7, asynchronous
- sr_pl_n  output  1  parallel load, active low
- sr_cp  output  1  shift clock to CP of all chips
- sr_ce_n  output  1  clock enable, active low
- data  output  NUM_BITS  last completed scan, first bit shifted out in MSB
- valid  output  1  one-cycle strobe when data updates
- busy  output  1  high from start acceptance until the cycle valid asserts

## Operation

- Reset values: sr_pl_n=1, sr_cp=0, sr_ce_n=1, data=0, valid=0, busy=0; FSM in IDLE; sync flops and counters cleared.
- sr_q7 goes through a 2-flop synchroniser (q7_s); only q7_s is sampled.
- FSM states: IDLE, LOAD, RECOVER, SHIFT_LO, SHIFT_HI, DONE.
- IDLE: on start=1, go to LOAD and set busy=1. start is ignored in all other states.
- LOAD: sr_pl_n=0 for PL_CYCLES cycles, then go to RECOVER.
- RECOVER: sr_pl_n=1 for REC_CYCLES cycles, then go to SHIFT_LO with bit index 0.
- SHIFT_LO: sr_cp=0, sr_ce_n=0 for CP_HALF cycles. On the last cycle, shift q7_s into the shift accumulator at the LSB end, so the first bit lands in the MSB after NUM_BITS shifts. If the index is NUM_BITS-1, go to DONE. Otherwise go to SHIFT_HI.
- SHIFT_HI: sr_cp=1, sr_ce_n=0 for CP_HALF cycles. Increment the index, then go to SHIFT_LO.
- The chain therefore sees exactly NUM_BITS-1 sr_cp rising edges per scan.
- DONE: transient, entered on the edge of the final sample. Load data from the accumulator, set valid=1 for one cycle, clear busy, and return to IDLE.
- With start held high, scans run back to back with one IDLE cycle between them.
- sr_ce_n is low only in SHIFT_LO and SHIFT_HI. sr_cp rises only while sr_ce_n=0 and sr_pl_n=1.
- data holds its value between scans. It never shows a partial accumulation.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Latency: if start is captured at edge 0, sr_pl_n falls after edge 1.
- valid is high in the cycle after edge 1+PL_CYCLES+REC_CYCLES+(2·NUM_BITS−1)·CP_HALF. With defaults this is edge 130.
- sr_cp period is 2·CP_HALF cycles at 50% duty.
- Each sample is taken ≥CP_HALF−2 cycles after the preceding sr_cp rise, which covers the synchroniser delay.
- NUM_BITS=1 case: SHIFT_HI is never entered and sr_cp never toggles.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronous). data is cleared. No valid is issued for the aborted scan.
- Scan period with start held: 1+PL_CYCLES+REC_CYCLES+(2·NUM_BITS−1)·CP_HALF+1 cycles.

## Test plan

- Reset then idle: rst_n low for 3 cycles, then high for 20 cycles with start=0. Outputs stay at reset values: sr_pl_n=1, sr_cp=0, sr_ce_n=1, valid=0.
- Single scan, two chained 74HC165 models loaded with 8'b10101010 each, defaults. Required response:
  - one valid pulse with data=16'hAAAA;
  - exactly 15 sr_cp rises;
  - sr_pl_n low for exactly 2 cycles;
  - valid at edge 130.
- Back-to-back scans with start held high; chip inputs change between scans 8'h55 → 8'hF0 → 8'h0F. data sequence is 16'h5555, 16'hF0F0, 16'h0F0F. Valid pulses are 131 cycles apart.
- Start while busy: pulse start mid-SHIFT. No second scan starts and the timing of the current scan is unchanged.
- Reset mid-scan: assert rst_n during the 5th SHIFT_HI. Outputs go to reset values in the same cycle and no valid is issued. The next start yields a correct full scan.
- Parameter corners: NUM_BITS=1, CP_HALF=3 with one chip of 8'h80 gives data=1'b1 and no sr_cp edges. NUM_BITS=8 with 8'h01 gives data=8'h01.

Source files
------------

// File: rtl/hc165_scan_if.sv
// Pin and result bundle between the 74HC165 scan sequencer and its neighbours.
// The master modport is the sequencer; the slave modport is the chain/consumer side.
interface hc165_scan_if #(
    parameter int NUM_BITS = 16
);
    logic                start;
    logic                sr_q7;
    logic                sr_pl_n;
    logic                sr_cp;
    logic                sr_ce_n;
    logic [NUM_BITS-1:0] data;
    logic                valid;
    logic                busy;

    modport master (
        input  start, sr_q7,
        output sr_pl_n, sr_cp, sr_ce_n, data, valid, busy
    );

    modport slave (
        output start, sr_q7,
        input  sr_pl_n, sr_cp, sr_ce_n, data, valid, busy
    );
endinterface

// File: rtl/hc165_scan_ctrl.sv
// Load/recover/shift sequencer for a 74HC165 daisy chain with parallel word output.
// Pin controls are registered from the current state, so they trail the FSM by one clk.
module hc165_scan_ctrl #(
    parameter int NUM_BITS   = 16,
    parameter int CP_HALF    = 4,
    parameter int PL_CYCLES  = 2,
    parameter int REC_CYCLES = 3
) (
    input logic          clk,
    input logic          rst_n,
    hc165_scan_if.master scan
);
    localparam int CNT_MAX_A = (PL_CYCLES > REC_CYCLES) ? PL_CYCLES : REC_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CP_HALF) ? CNT_MAX_A : CP_HALF;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [CNT_W-1:0] PL_LAST  = CNT_W'(PL_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RECOVER,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] acc_q, acc_d;
    logic [NUM_BITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                pl_n_q, pl_n_d;
    logic                cp_q, cp_d;
    logic                ce_n_q, ce_n_d;
    logic                q7_s1_q, q7_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            pl_n_q  <= 1'b1;
            cp_q    <= 1'b0;
            ce_n_q  <= 1'b1;
            q7_s1_q <= 1'b0;
            q7_s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            pl_n_q  <= pl_n_d;
            cp_q    <= cp_d;
            ce_n_q  <= ce_n_d;
            q7_s1_q <= scan.sr_q7;
            q7_s_q  <= q7_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        pl_n_d  = 1'b1;
        cp_d    = 1'b0;
        ce_n_d  = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (scan.start) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                pl_n_d = 1'b0;
                if (cnt_q == PL_LAST) begin
                    cnt_d   = '0;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = SHIFT_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT_LO: begin
                ce_n_d = 1'b0;
                if (cnt_q == CP_LAST) begin
                    // Sample at the end of the low phase, long after the previous CP rise.
                    cnt_d   = '0;
                    acc_d   = (acc_q << 1) | NUM_BITS'(q7_s_q);
                    state_d = (idx_q == IDX_LAST) ? DONE : SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT_HI: begin
                cp_d   = 1'b1;
                ce_n_d = 1'b0;
                if (cnt_q == CP_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SHIFT_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                data_d  = acc_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan.sr_pl_n = pl_n_q;
    assign scan.sr_cp   = cp_q;
    assign scan.sr_ce_n = ce_n_q;
    assign scan.data    = data_q;
    assign scan.valid   = valid_q;
    assign scan.busy    = busy_q;
endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Bench for hc165_scan_ctrl: behavioural 74HC165 chains feed three differently sized sequencers.
// Expected words are queued when a scan is launched and compared when valid strobes.
module tb_hc165_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc165_scan_if #(.NUM_BITS(16)) if0 ();
    hc165_scan_if #(.NUM_BITS(1))  if1 ();
    hc165_scan_if #(.NUM_BITS(8))  if2 ();

    hc165_scan_ctrl #(.NUM_BITS(16), .CP_HALF(4), .PL_CYCLES(2), .REC_CYCLES(3))
        u0 (.clk(clk), .rst_n(rst_n), .scan(if0));
    hc165_scan_ctrl #(.NUM_BITS(1), .CP_HALF(3), .PL_CYCLES(2), .REC_CYCLES(3))
        u1 (.clk(clk), .rst_n(rst_n), .scan(if1));
    hc165_scan_ctrl #(.NUM_BITS(8), .CP_HALF(4), .PL_CYCLES(2), .REC_CYCLES(3))
        u2 (.clk(clk), .rst_n(rst_n), .scan(if2));

    // Chain models: asynchronous parallel load on PL_n low, shift on CP rise with CE_n low.
    logic [15:0] par0 = '0, ch0 = '0;
    logic [7:0]  par1 = '0, ch1 = '0;
    logic [7:0]  par2 = '0, ch2 = '0;

    always @(negedge if0.sr_pl_n or posedge if0.sr_cp)
        if (!if0.sr_pl_n) ch0 <= par0;
        else if (!if0.sr_ce_n) ch0 <= {ch0[14:0], 1'b0};
    always @(negedge if1.sr_pl_n or posedge if1.sr_cp)
        if (!if1.sr_pl_n) ch1 <= par1;
        else if (!if1.sr_ce_n) ch1 <= {ch1[6:0], 1'b0};
    always @(negedge if2.sr_pl_n or posedge if2.sr_cp)
        if (!if2.sr_pl_n) ch2 <= par2;
        else if (!if2.sr_ce_n) ch2 <= {ch2[6:0], 1'b0};

    assign if0.sr_q7 = ch0[15];
    assign if1.sr_q7 = ch1[7];
    assign if2.sr_q7 = ch2[7];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int vcnt[3] = '{0, 0, 0};
    int last_vedge[3] = '{0, 0, 0};
    int cp_rise[3] = '{0, 0, 0};
    int pl_low[3] = '{0, 0, 0};
    logic cp_prev[3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] sb0[$];
    logic [15:0] sb1[$];
    logic [15:0] sb2[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_one(input int k, input logic cp, input logic pl_n,
                           input logic vld, input logic [15:0] d);
        int n;
        logic [15:0] e;
        if (cp === 1'b1 && cp_prev[k] !== 1'b1) cp_rise[k]++;
        cp_prev[k] = cp;
        if (pl_n === 1'b0) pl_low[k]++;
        if (vld === 1'b1) begin
            vcnt[k]++;
            last_vedge[k] = edge_cnt;
            case (k)
                0:       n = sb0.size();
                1:       n = sb1.size();
                default: n = sb2.size();
            endcase
            check_val($sformatf("sb_nonempty%0d", k), (n > 0) ? 1 : 0, 1);
            if (n > 0) begin
                case (k)
                    0:       e = sb0.pop_front();
                    1:       e = sb1.pop_front();
                    default: e = sb2.pop_front();
                endcase
                check_val($sformatf("data%0d", k), int'(d), int'(e));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        mon_one(0, if0.sr_cp, if0.sr_pl_n, if0.valid, if0.data);
        mon_one(1, if1.sr_cp, if1.sr_pl_n, if1.valid, {15'b0, if1.data});
        mon_one(2, if2.sr_cp, if2.sr_pl_n, if2.valid, {8'b0, if2.data});
    endtask

    task automatic wait_valid(input int k, input int bound);
        int v0 = vcnt[k];
        int n = 0;
        while (vcnt[k] == v0 && n < bound) begin
            tick();
            n++;
        end
        check_val($sformatf("valid_seen%0d", k), vcnt[k] - v0, 1);
    endtask

    task automatic set_start(input int k, input logic v);
        case (k)
            0:       if0.start = v;
            1:       if1.start = v;
            default: if2.start = v;
        endcase
    endtask

    // Launch one scan on instance k; returns the edge that captured start.
    task automatic launch(input int k, output int e0);
        set_start(k, 1'b1);
        tick();
        e0 = edge_cnt;
        set_start(k, 1'b0);
    endtask

    task automatic full_scan(input int k, input int lat, input int rises);
        int e0, cp0, pl0;
        cp0 = cp_rise[k];
        pl0 = pl_low[k];
        launch(k, e0);
        wait_valid(k, 400);
        check_val($sformatf("latency%0d", k), last_vedge[k] - e0, lat);
        check_val($sformatf("cp_rises%0d", k), cp_rise[k] - cp0, rises);
        check_val($sformatf("pl_width%0d", k), pl_low[k] - pl0, 2);
    endtask

    initial begin
        int dev, e0, k1, vsnap;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;

        repeat (3) tick();
        check_val("rst_pl_n", if0.sr_pl_n, 1);
        check_val("rst_cp", if0.sr_cp, 0);
        check_val("rst_ce_n", if0.sr_ce_n, 1);
        check_val("rst_valid", if0.valid, 0);
        check_val("rst_busy", if0.busy, 0);
        check_val("rst_data", if0.data, 0);
        rst_n = 1'b1;
        dev = 0;
        repeat (20) begin
            tick();
            if (if0.sr_pl_n !== 1'b1 || if0.sr_cp !== 1'b0 || if0.sr_ce_n !== 1'b1 ||
                if0.valid !== 1'b0 || if0.busy !== 1'b0) dev++;
        end
        check_val("idle_dev", dev, 0);

        // Single scan, two chips of 8'b10101010.
        par0 = 16'hAAAA;
        sb0.push_back(par0);
        full_scan(0, 130, 15);
        check_val("busy_after", if0.busy, 0);

        // Back-to-back with start held high.
        par0 = 16'h5555;
        sb0.push_back(par0);
        if0.start = 1'b1;
        wait_valid(0, 400);
        k1 = last_vedge[0];
        par0 = 16'hF0F0;
        sb0.push_back(par0);
        wait_valid(0, 400);
        check_val("b2b_period1", last_vedge[0] - k1, 131);
        k1 = last_vedge[0];
        par0 = 16'h0F0F;
        sb0.push_back(par0);
        wait_valid(0, 400);
        check_val("b2b_period2", last_vedge[0] - k1, 131);
        if0.start = 1'b0;
        vsnap = vcnt[0];
        repeat (150) tick();
        check_val("b2b_stop", vcnt[0] - vsnap, 0);

        // Start pulsed while busy must be ignored.
        par0 = 16'h1234;
        sb0.push_back(par0);
        launch(0, e0);
        repeat (60) tick();
        check_val("busy_mid", if0.busy, 1);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        wait_valid(0, 400);
        check_val("busy_latency", last_vedge[0] - e0, 130);
        vsnap = vcnt[0];
        repeat (150) tick();
        check_val("busy_no_rescan", vcnt[0] - vsnap, 0);
        check_val("busy_idle", if0.busy, 0);

        // Reset in the 5th SHIFT_HI; no expectation queued for the aborted scan.
        par0 = 16'hFFFF;
        launch(0, e0);
        repeat (43) tick();
        check_val("pre_rst_cp", if0.sr_cp, 1);
        check_val("pre_rst_ce_n", if0.sr_ce_n, 0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_pl_n", if0.sr_pl_n, 1);
        check_val("mid_rst_cp", if0.sr_cp, 0);
        check_val("mid_rst_ce_n", if0.sr_ce_n, 1);
        check_val("mid_rst_valid", if0.valid, 0);
        check_val("mid_rst_busy", if0.busy, 0);
        check_val("mid_rst_data", if0.data, 0);
        vsnap = vcnt[0];
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (150) tick();
        check_val("rst_no_valid", vcnt[0] - vsnap, 0);
        par0 = 16'hC3A5;
        sb0.push_back(par0);
        full_scan(0, 130, 15);

        // Single-bit chain, CP_HALF=3.
        par1 = 8'h80;
        sb1.push_back(16'h0001);
        full_scan(1, 9, 0);
        par1 = 8'h7F;
        sb1.push_back(16'h0000);
        full_scan(1, 9, 0);

        // One full chip.
        par2 = 8'h01;
        sb2.push_back(16'h0001);
        full_scan(2, 66, 7);
        par2 = 8'hB6;
        sb2.push_back(16'h00B6);
        full_scan(2, 66, 7);

        check_val("sb0_left", sb0.size(), 0);
        check_val("sb1_left", sb1.size(), 0);
        check_val("sb2_left", sb2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
